mem_port_arbiter: RTL and testbench

//  Shares the single-port, synchronous-read memWrapper between the CPU instruction-fetch

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its two requesters (I fetch, D load/store) and memWrapper.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              IAck;
    logic [DATA_W-1:0] IData;
    logic              IErr;

    logic              DReq;
    logic              DWE;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic              DAck;
    logic [DATA_W-1:0] DRData;
    logic              DErr;

    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemDIn;
    logic              MemWE;
    logic [DATA_W-1:0] MemDOut;
    logic              MemOOB;

    logic              Busy;

    modport slave (
        input  IReq, IAddr, DReq, DWE, DAddr, DWData, MemDOut, MemOOB,
        output IAck, IData, IErr, DAck, DRData, DErr, MemAddr, MemDIn, MemWE, Busy
    );

    modport master (
        output IReq, IAddr, DReq, DWE, DAddr, DWData, MemDOut, MemOOB,
        input  IAck, IData, IErr, DAck, DRData, DErr, MemAddr, MemDIn, MemWE, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read memory between an I fetch port and a D read/write port.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests instead of fixed D>I.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter bit INIT_LAST = 1'b0
) (
    input  logic               CLK,
    input  logic               Reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic              r_grant_d;
    logic              w_pick_d;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // On a collision the port that was not granted last wins.
    assign w_pick_d = bus.DReq & (~bus.IReq | ~r_last_d);
`else
    localparam bit init_last_unused = INIT_LAST;

    assign w_pick_d = bus.DReq;
`endif

    assign w_addr  = w_pick_d ? bus.DAddr  : bus.IAddr;
    assign w_wdata = w_pick_d ? bus.DWData : '0;

    // Gated combinationally so out-of-bounds writes and writes aborted by reset never reach memory.
    assign bus.MemWE = (r_state == ST_ISSUE) & r_we & ~bus.MemOOB & ~Reset;
    assign bus.Busy  = (r_state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_grant_d   <= 1'b0;
            bus.IAck    <= 1'b0;
            bus.IData   <= '0;
            bus.IErr    <= 1'b0;
            bus.DAck    <= 1'b0;
            bus.DRData  <= '0;
            bus.DErr    <= 1'b0;
            bus.MemAddr <= '0;
            bus.MemDIn  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= INIT_LAST;
`endif
        end else begin
            bus.IAck <= 1'b0;
            bus.DAck <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.IReq | bus.DReq) begin
                        bus.MemAddr <= w_addr;
                        bus.MemDIn  <= w_wdata;
                        r_we        <= w_pick_d & bus.DWE;
                        r_grant_d   <= w_pick_d;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_d    <= w_pick_d;
`endif
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_grant_d) begin
                        bus.DRData <= bus.MemDOut;
                        bus.DErr   <= bus.MemOOB;
                        bus.DAck   <= 1'b1;
                    end else begin
                        bus.IData  <= bus.MemDOut;
                        bus.IErr   <= bus.MemOOB;
                        bus.IAck   <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model, directed cases, random traffic.
// A 1024-word write-first memory stands in for memWrapper (preloaded mem[a]=a, OOB for a>=1024).
module tb_mem_port_arbiter;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_WORDS = 1024;
    localparam bit INIT_LAST = 1'b1;

    logic CLK = 1'b0;
    logic Reset;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_LAST(INIT_LAST)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // memWrapper stand-in
    logic [DATA_W-1:0] mem [0:MEM_WORDS-1];
    logic [9:0]        w_idx;
    int unsigned       wr_count = 0;

    assign w_idx      = bus.MemAddr[9:0];
    assign bus.MemOOB = (bus.MemAddr >= 16'(MEM_WORDS));

    always @(posedge CLK) begin
        if (!bus.MemOOB) begin
            if (bus.MemWE === 1'b1) begin
                mem[w_idx]  <= bus.MemDIn;
                bus.MemDOut <= bus.MemDIn;
            end else begin
                bus.MemDOut <= mem[w_idx];
            end
        end else begin
            bus.MemDOut <= '0;
        end
        if (bus.MemWE === 1'b1) wr_count <= wr_count + 1;
    end

    // Reference model: one transaction record, expected outputs derived from request timing rules
    logic [DATA_W-1:0] ref_mem [0:MEM_WORDS-1];
    int unsigned       e_no = 0;
    bit                t_act = 0, t_d = 0, t_we = 0, t_err = 0, last_d = INIT_LAST;
    int unsigned       t0 = 0;
    logic [ADDR_W-1:0] t_addr = '0;
    logic [DATA_W-1:0] t_wdata = '0, t_res = '0;
    logic              exp_iack = 0, exp_dack = 0, exp_ierr = 0, exp_derr = 0;
    logic [DATA_W-1:0] exp_idata = '0, exp_drdata = '0;

    int unsigned       n_pass = 0, n_total = 0;
    int unsigned       i_acks = 0, d_acks = 0, last_i_edge = 0, last_d_edge = 0;
    logic [DATA_W-1:0] last_i_data = '0, last_d_data = '0;
    logic              last_i_err = 0, last_d_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, e_no);
    endtask

    task automatic model_edge();
        bit pick_d;
        e_no++;
        exp_iack = 0;
        exp_dack = 0;
        if (Reset) begin
            t_act = 0;
            exp_idata = '0; exp_drdata = '0; exp_ierr = 0; exp_derr = 0;
            last_d = INIT_LAST;
            return;
        end
        if (t_act && e_no == t0 + 1) begin
            t_err = (t_addr >= 16'(MEM_WORDS));
            if (!t_err && t_we) ref_mem[t_addr[9:0]] = t_wdata;
            t_res = t_err ? '0 : ref_mem[t_addr[9:0]];
        end else if (t_act && e_no == t0 + 2) begin
            if (t_d) begin
                exp_dack = 1; exp_drdata = t_res; exp_derr = t_err;
            end else begin
                exp_iack = 1; exp_idata = t_res; exp_ierr = t_err;
            end
            t_act = 0;
        end else if (!t_act && (bus.IReq || bus.DReq)) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_d = bus.DReq && (!bus.IReq || !last_d);
`else
            pick_d = bus.DReq;
`endif
            t_act   = 1;
            t0      = e_no;
            t_d     = pick_d;
            t_we    = pick_d && bus.DWE;
            t_addr  = pick_d ? bus.DAddr : bus.IAddr;
            t_wdata = bus.DWData;
            last_d  = pick_d;
        end
    endtask

    task automatic compare();
        logic exp_we;
        exp_we = t_act && (e_no == t0) && t_we && (t_addr < 16'(MEM_WORDS)) && !Reset;
        chk("IAck",   {31'd0, bus.IAck},  {31'd0, exp_iack});
        chk("DAck",   {31'd0, bus.DAck},  {31'd0, exp_dack});
        chk("IData",  {16'd0, bus.IData}, {16'd0, exp_idata});
        chk("DRData", {16'd0, bus.DRData}, {16'd0, exp_drdata});
        if (exp_iack) chk("IErr", {31'd0, bus.IErr}, {31'd0, exp_ierr});
        if (exp_dack) chk("DErr", {31'd0, bus.DErr}, {31'd0, exp_derr});
        chk("Busy",   {31'd0, bus.Busy},  {31'd0, t_act});
        chk("MemWE",  {31'd0, bus.MemWE}, {31'd0, exp_we});
        if (bus.IAck === 1'b1) begin
            i_acks++; last_i_edge = e_no; last_i_data = bus.IData; last_i_err = bus.IErr;
        end
        if (bus.DAck === 1'b1) begin
            d_acks++; last_d_edge = e_no; last_d_data = bus.DRData; last_d_err = bus.DErr;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare();
    endtask

    task automatic wait_ack(input bit want_d, input string nm);
        bit ok;
        ok = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if ((want_d ? bus.DAck : bus.IAck) === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: got no ack, expected ack within 12 cycles", nm);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 16'(MEM_WORDS + $urandom_range(0, 65535 - MEM_WORDS));
        return 16'($urandom_range(0, MEM_WORDS - 1));
    endfunction

    initial begin
        int unsigned req_e, wr0, d0, ack_e[4];
        logic [DATA_W-1:0] got[4];
        bit first_d, seen;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 16'(i);
            ref_mem[i] = 16'(i);
        end
        Reset = 1;
        bus.IReq = 0; bus.IAddr = '0;
        bus.DReq = 0; bus.DWE = 0; bus.DAddr = '0; bus.DWData = '0;
        step();
        step();
        chk("rst_IAck",    {31'd0, bus.IAck}, 32'd0);
        chk("rst_IData",   {16'd0, bus.IData}, 32'd0);
        chk("rst_MemAddr", {16'd0, bus.MemAddr}, 32'd0);
        chk("rst_Busy",    {31'd0, bus.Busy}, 32'd0);
        Reset = 0;
        step();

        // 1: single fetch, latency
        bus.IReq = 1; bus.IAddr = 16'd23; req_e = e_no + 1;
        wait_ack(0, "t1_ack");
        bus.IReq = 0;
        chk("t1_idata", {16'd0, last_i_data}, 32'd23);
        chk("t1_ierr",  {31'd0, last_i_err}, 32'd0);
        chk("t1_lat",   last_i_edge - req_e, 32'd2);
        step();

        // 2: write then read back, exactly one write strobe
        wr0 = wr_count;
        bus.DReq = 1; bus.DWE = 1; bus.DAddr = 16'd332; bus.DWData = 16'd166;
        wait_ack(1, "t2_wack");
        chk("t2_wdata", {16'd0, last_d_data}, 32'd166);
        bus.DWE = 0;
        wait_ack(1, "t2_rack");
        bus.DReq = 0;
        chk("t2_rdata", {16'd0, last_d_data}, 32'd166);
        chk("t2_wecnt", wr_count - wr0, 32'd1);
        step();

        // 3: collision
        bus.IReq = 1; bus.IAddr = 16'd3; bus.DReq = 1; bus.DWE = 0; bus.DAddr = 16'd63;
        seen = 0; first_d = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            step();
            if (bus.DAck === 1'b1 || bus.IAck === 1'b1) begin
                seen = 1; first_d = bus.DAck;
            end
        end
        if (!seen) begin n_total++; $display("FAIL t3_first: got no ack, expected ack within 12 cycles"); end
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_first_d", {31'd0, first_d}, 32'd0);
`else
        chk("t3_first_d", {31'd0, first_d}, 32'd1);
`endif
        if (first_d) begin
            chk("t3_d", {16'd0, last_d_data}, 32'd63);
            bus.DReq = 0;
            wait_ack(0, "t3_iack");
            chk("t3_i", {16'd0, last_i_data}, 32'd3);
            bus.IReq = 0;
        end else begin
            chk("t3_i", {16'd0, last_i_data}, 32'd3);
            bus.IReq = 0;
            wait_ack(1, "t3_dack");
            chk("t3_d", {16'd0, last_d_data}, 32'd63);
            bus.DReq = 0;
        end
        step();

        // 4: out-of-bounds write
        wr0 = wr_count;
        bus.DReq = 1; bus.DWE = 1; bus.DAddr = 16'hFFFF; bus.DWData = 16'h1234;
        wait_ack(1, "t4_ack");
        bus.DReq = 0; bus.DWE = 0;
        chk("t4_derr",  {31'd0, last_d_err}, 32'd1);
        chk("t4_wecnt", wr_count - wr0, 32'd0);
        bus.IReq = 1; bus.IAddr = 16'd1;
        wait_ack(0, "t4_iack");
        bus.IReq = 0;
        chk("t4_idata", {16'd0, last_i_data}, 32'd1);
        step();

        // 5: reset during ISSUE aborts the write
        d0 = d_acks;
        bus.DReq = 1; bus.DWE = 1; bus.DAddr = 16'd1023; bus.DWData = 16'hFFFF;
        step();
        Reset = 1;
        step();
        chk("t5_busy", {31'd0, bus.Busy}, 32'd0);
        Reset = 0; bus.DReq = 0; bus.DWE = 0;
        for (int k = 0; k < 4; k++) step();
        chk("t5_noack", d_acks - d0, 32'd0);
        bus.DReq = 1; bus.DAddr = 16'd1023;
        wait_ack(1, "t5_rack");
        bus.DReq = 0;
        chk("t5_rdata", {16'd0, last_d_data}, 32'd1023);
        step();

        // 6: held fetch stream, address changed at each ack
        bus.IReq = 1; bus.IAddr = 16'd1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, "t6_ack");
            got[k] = last_i_data; ack_e[k] = last_i_edge;
            bus.IAddr = (k == 0) ? 16'd2 : (k == 1) ? 16'd3 : 16'd654;
        end
        bus.IReq = 0;
        chk("t6_d0", {16'd0, got[0]}, 32'd1);
        chk("t6_d1", {16'd0, got[1]}, 32'd2);
        chk("t6_d2", {16'd0, got[2]}, 32'd3);
        chk("t6_d3", {16'd0, got[3]}, 32'd654);
        for (int k = 1; k < 4; k++) chk("t6_gap", ack_e[k] - ack_e[k-1], 32'd3);
        step();

        // random traffic, occasional drops and resets
        for (int c = 0; c < 1500; c++) begin
            if (bus.IReq == 0 || bus.IAck === 1'b1) begin
                bus.IReq  = ($urandom_range(0, 2) != 0);
                bus.IAddr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                bus.IReq = 0;
            end
            if (bus.DReq == 0 || bus.DAck === 1'b1) begin
                bus.DReq   = ($urandom_range(0, 2) != 0);
                bus.DWE    = $urandom_range(0, 1) != 0;
                bus.DAddr  = rand_addr();
                bus.DWData = 16'($urandom_range(0, 65535));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.DReq = 0;
            end
            Reset = ($urandom_range(0, 99) == 0);
            step();
        end
        Reset = 0; bus.IReq = 0; bus.DReq = 0;
        for (int k = 0; k < 5; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
